cpu_run_ctrl: RTL
=================

CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 The block SHALL have parameter RST_CYCLES, default 2, which sets the number of clk cycles that cpu_rst_n is held low in RESET (minimum 1).
REQ-002 The block SHALL have parameter MAX_CYCLES, default 40, which sets the run-cycle budget before timeout.
REQ-003 The block SHALL have parameter CNT_W, default 32, which sets the cycle counter width; MAX_CYCLES SHALL fit in CNT_W bits.
REQ-004 The block SHALL have parameter STALL_CYCLES, default 8, which sets how many consecutive cycles with the same pc count as a stall.
REQ-005 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-006 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 Port start, input, 1 bit: single-cycle pulse that begins, or restarts, a run.
REQ-008 Port halt_valid, input, 1 bit: the CPU wrote the tohost word this cycle.
REQ-009 Port halt_code, input, 32 bits: the tohost value.
REQ-010 Port pc, input, 32 bits: the CPU program counter, used for stall detection.
REQ-011 Port cpu_rst_n, output, 1 bit: active-low reset to the CPU, registered.
REQ-012 Port running, output, 1 bit: high while in RUN.
REQ-013 Port done, output, 1 bit: high while in DONE.
REQ-014 Port pass, output, 1 bit: result flag, valid while done is high.
REQ-015 Port timeout, output, 1 bit: the run ended because the cycle budget was exhausted.
REQ-016 Port stall, output, 1 bit: the run ended because pc stopped changing.
REQ-017 Port cycle_cnt, output, CNT_W bits: number of RUN cycles elapsed.
REQ-018 Port result_code, output, 32 bits: latched halt_code.

Function
REQ-019 The state machine SHALL have exactly four states: IDLE, RESET, RUN and DONE.
REQ-020 In IDLE, cpu_rst_n SHALL be 0; a start pulse SHALL move to RESET on the next edge.
REQ-021 On entering RESET, cycle_cnt, pass, timeout, stall and result_code SHALL be cleared.
REQ-022 RESET SHALL last exactly RST_CYCLES cycles with cpu_rst_n=0, then move to RUN.
REQ-023 cpu_rst_n SHALL be 1 in every cycle in which the state is RUN.
REQ-024 In RUN, cycle_cnt SHALL increment by 1 per cycle and saturate at all-ones (no wrap-around).
REQ-025 In RUN with halt_valid=1, the block SHALL latch result_code=halt_code, set pass=1 if halt_code==1 else pass=0, and move to DONE on the next edge.
REQ-026 In RUN, if halt_valid=0 in the cycle where cycle_cnt==MAX_CYCLES-1, the block SHALL set timeout=1 and pass=0 and move to DONE.
REQ-027 If halt and timeout or stall occur in the same cycle, the halt SHALL take priority and timeout and stall SHALL stay 0.
REQ-028 If timeout and stall occur in the same cycle, stall=1 and timeout=0.
REQ-029 In DONE, cpu_rst_n SHALL be 0 (CPU frozen), and all status outputs SHALL be sticky.
REQ-030 In DONE, halt_valid and pc SHALL be ignored.
REQ-031 start in RUN or DONE SHALL abort or restart: the next state is RESET, with the status clear of REQ-021.
REQ-032 start in RESET SHALL restart the RST_CYCLES count.
REQ-033 running SHALL equal (state==RUN) and done SHALL equal (state==DONE); both SHALL be registered-state decodes with no input-to-output combinational path.

Reset
REQ-034 While rst=1, the block SHALL immediately force state=IDLE, cpu_rst_n=0, running=0, done=0, pass=0, timeout=0, stall=0, cycle_cnt=0 and result_code=0, regardless of clk.
REQ-035 rst asserted mid-RUN SHALL abandon the run with no DONE pulse.
REQ-036 After rst is released, the block SHALL wait in IDLE for start.

Configuration
REQ-037 When macro RUN_CTRL_STALL_DETECT_EN is defined, the block SHALL count consecutive RUN cycles with pc equal to the previous cycle's pc.
REQ-038 With the macro defined, the stall counter SHALL reset to 0 on any pc change and on entering RUN.
REQ-039 With the macro defined, when the count reaches STALL_CYCLES the block SHALL set stall=1 and pass=0 and move to DONE.
REQ-040 When the macro is undefined, the stall output SHALL be tied to 0, the pc input SHALL be unused, and no stall-counter logic SHALL be present.

Verification
REQ-041 Scenario: defaults; start at cycle 3; halt_valid with halt_code=1 at RUN cycle 10 -> done=1, pass=1, result_code=1, cycle_cnt=11, cpu_rst_n=0.
REQ-042 Scenario: halt_code=0x7 -> done=1, pass=0, result_code=0x7, timeout=0.
REQ-043 Scenario: no halt, pc incrementing by 4 each cycle -> done after 40 RUN cycles, timeout=1, pass=0, cycle_cnt=40.
REQ-044 Scenario: RUN_CTRL_STALL_DETECT_EN defined, pc held at 0x10 from RUN cycle 5 -> stall=1 at cycle 13, pass=0, timeout=0; with the macro undefined, the same stimulus -> timeout=1.
REQ-045 Scenario: halt_valid=1 in the cycle where cycle_cnt==39 -> pass per halt_code, timeout=0.
REQ-046 Scenario: rst pulse mid-RUN, then start -> all outputs 0 asynchronously; cpu_rst_n low for exactly 2 cycles, then RUN with cycle_cnt restarting at 0.

Source files
------------

// File: rtl/cpu_run_ctrl_if.sv
// cpu_run_ctrl_if: groups the run-control handshake between the test harness side
// (master: drives start/halt/pc) and the controller (slave: drives reset and status).
interface cpu_run_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             start;
    logic             halt_valid;
    logic [31:0]      halt_code;
    logic [31:0]      pc;
    logic             cpu_rst_n;
    logic             running;
    logic             done;
    logic             pass;
    logic             timeout;
    logic             stall;
    logic [CNT_W-1:0] cycle_cnt;
    logic [31:0]      result_code;

    modport master (
        output start, halt_valid, halt_code, pc,
        input  cpu_rst_n, running, done, pass, timeout, stall, cycle_cnt, result_code
    );

    modport slave (
        input  start, halt_valid, halt_code, pc,
        output cpu_rst_n, running, done, pass, timeout, stall, cycle_cnt, result_code
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: sequences a CPU through reset and a bounded run, then records how the
// run ended (halt code, cycle-budget timeout, or pc stall).
// Optional feature: define RUN_CTRL_STALL_DETECT_EN to enable pc-stall detection;
// without it the stall output stays 0 and pc is ignored.
module cpu_run_ctrl #(
    parameter int unsigned RST_CYCLES   = 2,
    parameter int unsigned MAX_CYCLES   = 40,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned STALL_CYCLES = 8
) (
    input  logic          clk,
    input  logic          rst,
    cpu_run_ctrl_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StReset, StRun, StDone} state_e;

    localparam int unsigned RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    state_e           r_state, w_state_nxt;
    logic [RW-1:0]    r_rst_cnt, w_rst_cnt_nxt;
    logic [CNT_W-1:0] r_cycle_cnt, w_cycle_cnt_nxt;
    logic [31:0]      r_result, w_result_nxt;
    logic             r_cpu_rst_n, w_cpu_rst_n_nxt;
    logic             r_pass, w_pass_nxt;
    logic             r_timeout, w_timeout_nxt;
    logic             r_stall, w_stall_nxt;
    logic             w_stall_hit;
    logic             w_last_cycle;
    logic [CNT_W-1:0] w_cnt_inc;

    // Saturating increment: the counter must never wrap back to zero.
    assign w_cnt_inc    = (&r_cycle_cnt) ? r_cycle_cnt : r_cycle_cnt + 1'b1;
    assign w_last_cycle = (r_cycle_cnt == CNT_W'(MAX_CYCLES - 1));

`ifdef RUN_CTRL_STALL_DETECT_EN
    localparam int unsigned SW = $clog2(STALL_CYCLES + 1);

    logic [31:0]   r_prev_pc;
    logic [SW-1:0] r_stall_cnt, w_stall_cnt_nxt;

    // Count this cycle if pc repeats; first RUN cycle (cycle_cnt==0) has no RUN predecessor.
    always_comb begin
        w_stall_cnt_nxt = '0;
        w_stall_hit     = 1'b0;
        if (r_state == StRun && r_cycle_cnt != '0 && bus.pc == r_prev_pc) begin
            w_stall_cnt_nxt = r_stall_cnt + 1'b1;
            w_stall_hit     = (w_stall_cnt_nxt == SW'(STALL_CYCLES));
        end
    end

    // Previous-pc sample and stall run length.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev_pc   <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_prev_pc   <= bus.pc;
            r_stall_cnt <= w_stall_cnt_nxt;
        end
    end
`else
    assign w_stall_hit = 1'b0;
`endif

    // State register and all status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_rst_cnt   <= '0;
            r_cycle_cnt <= '0;
            r_result    <= '0;
            r_cpu_rst_n <= 1'b0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
            r_stall     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rst_cnt   <= w_rst_cnt_nxt;
            r_cycle_cnt <= w_cycle_cnt_nxt;
            r_result    <= w_result_nxt;
            r_cpu_rst_n <= w_cpu_rst_n_nxt;
            r_pass      <= w_pass_nxt;
            r_timeout   <= w_timeout_nxt;
            r_stall     <= w_stall_nxt;
        end
    end

    // Next-state and status update; start always wins and re-enters RESET with status cleared.
    always_comb begin
        w_state_nxt     = r_state;
        w_rst_cnt_nxt   = r_rst_cnt;
        w_cycle_cnt_nxt = r_cycle_cnt;
        w_result_nxt    = r_result;
        w_pass_nxt      = r_pass;
        w_timeout_nxt   = r_timeout;
        w_stall_nxt     = r_stall;

        if (bus.start) begin
            w_state_nxt     = StReset;
            w_rst_cnt_nxt   = '0;
            w_cycle_cnt_nxt = '0;
            w_result_nxt    = '0;
            w_pass_nxt      = 1'b0;
            w_timeout_nxt   = 1'b0;
            w_stall_nxt     = 1'b0;
        end else begin
            unique case (r_state)
                StIdle: ;
                StReset: begin
                    if (r_rst_cnt == RW'(RST_CYCLES - 1)) begin
                        w_state_nxt = StRun;
                    end else begin
                        w_rst_cnt_nxt = r_rst_cnt + 1'b1;
                    end
                end
                StRun: begin
                    w_cycle_cnt_nxt = w_cnt_inc;
                    // Priority: halt, then stall, then timeout.
                    if (bus.halt_valid) begin
                        w_state_nxt  = StDone;
                        w_result_nxt = bus.halt_code;
                        w_pass_nxt   = (bus.halt_code == 32'd1);
                    end else if (w_stall_hit) begin
                        w_state_nxt = StDone;
                        w_stall_nxt = 1'b1;
                        w_pass_nxt  = 1'b0;
                    end else if (w_last_cycle) begin
                        w_state_nxt   = StDone;
                        w_timeout_nxt = 1'b1;
                        w_pass_nxt    = 1'b0;
                    end
                end
                StDone: ;
                default: w_state_nxt = StIdle;
            endcase
        end

        // Registered so cpu_rst_n is high exactly in the RUN cycles.
        w_cpu_rst_n_nxt = (w_state_nxt == StRun);
    end

    assign bus.cpu_rst_n   = r_cpu_rst_n;
    assign bus.running     = (r_state == StRun);
    assign bus.done        = (r_state == StDone);
    assign bus.pass        = r_pass;
    assign bus.timeout     = r_timeout;
    assign bus.stall       = r_stall;
    assign bus.cycle_cnt   = r_cycle_cnt;
    assign bus.result_code = r_result;

endmodule
